// File: rtl/latch_sampler_pkg.sv
// Shared types and helpers for the latch sampler: FSM state encoding and
// sizing of the debounce stability counter.
package latch_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } sampler_state_t;

  function automatic int stab_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/latch_sampler_if.sv
// Bus between the latch sampler and its controller: async latch level and
// clear in, debounced level, edge pulses, event counters and overflow out.
interface latch_sampler_if #(
  parameter int CNT_WIDTH = 8
) ();
  logic                 q_async;
  logic                 clear;
  logic                 level;
  logic                 rise;
  logic                 fall;
  logic [CNT_WIDTH-1:0] rise_count;
  logic [CNT_WIDTH-1:0] fall_count;
  logic                 overflow;

  modport master (
    output q_async, clear,
    input  level, rise, fall, rise_count, fall_count, overflow
  );

  modport slave (
    input  q_async, clear,
    output level, rise, fall, rise_count, fall_count, overflow
  );
endinterface

// File: rtl/latch_sampler_sync_chain.sv
// Shift-register synchronizer, reset to 0; d appears on q after STAGES edges.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[STAGES-2:0], d};
    end
  end

  assign q = r_sh[STAGES-1];
endmodule

// File: rtl/latch_sampler.sv
// Synchronizes and debounces an async latch output into a clean level with
// rise/fall pulses and saturating counters; latency SYNC_STAGES+DEBOUNCE_CYCLES-1.
module latch_sampler
  import latch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic            clk,
  input  logic            rst,
  latch_sampler_if.slave  bus
);
  localparam int SW = stab_width(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0]        STAB_ONE  = SW'(1);
  localparam logic [SW-1:0]        STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 w_s;
  sampler_state_t       r_state;
  sampler_state_t       w_state_nxt;
  logic [SW-1:0]        r_stab;
  logic [SW-1:0]        w_stab_nxt;
  logic                 w_rise_evt;
  logic                 w_fall_evt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_WIDTH-1:0] r_rise_count;
  logic [CNT_WIDTH-1:0] r_fall_count;
  logic                 r_overflow;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.q_async),
    .q   (w_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW;
      r_stab  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stab  <= w_stab_nxt;
    end
  end

  // A single disagreeing sample in a CHK_* state returns to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    w_rise_evt  = 1'b0;
    w_fall_evt  = 1'b0;
    case (r_state)
      LOW: begin
        if (w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = HIGH;
            w_stab_nxt  = '0;
            w_rise_evt  = 1'b1;
          end else begin
            w_state_nxt = CHK_HIGH;
            w_stab_nxt  = STAB_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = LOW;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = HIGH;
          w_stab_nxt  = '0;
          w_rise_evt  = 1'b1;
        end else begin
          w_stab_nxt = r_stab + STAB_ONE;
        end
      end
      HIGH: begin
        if (!w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = LOW;
            w_stab_nxt  = '0;
            w_fall_evt  = 1'b1;
          end else begin
            w_state_nxt = CHK_LOW;
            w_stab_nxt  = STAB_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (w_s) begin
          w_state_nxt = HIGH;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = LOW;
          w_stab_nxt  = '0;
          w_fall_evt  = 1'b1;
        end else begin
          w_stab_nxt = r_stab + STAB_ONE;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_stab_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= (w_state_nxt == HIGH) || (w_state_nxt == CHK_LOW);
      r_rise  <= w_rise_evt;
      r_fall  <= w_fall_evt;
    end
  end

  // Clear wins over a same-edge event; the pulse itself is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise_count <= '0;
      r_fall_count <= '0;
      r_overflow   <= 1'b0;
    end else if (bus.clear) begin
      r_rise_count <= '0;
      r_fall_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_rise_evt) begin
        if (&r_rise_count) r_overflow <= 1'b1;
        else               r_rise_count <= r_rise_count + CNT_ONE;
      end
      if (w_fall_evt) begin
        if (&r_fall_count) r_overflow <= 1'b1;
        else               r_fall_count <= r_fall_count + CNT_ONE;
      end
    end
  end

  assign bus.level      = r_level;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.rise_count = r_rise_count;
  assign bus.fall_count = r_fall_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: doc/latch_sampler.md
Name: latch_sampler

Overview:
- Downstream stage for the level-sensitive latch. Samples the latch output `q`, which changes asynchronously to the system clock.
- Synchronizes `q` into the clock domain, debounces it, and produces a clean level plus single-cycle rise/fall pulses.
- Counts rise and fall events with saturating counters.
- Feeds control logic that must act on latch transitions exactly once.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required to accept a level change (legal range 1..255).
- CNT_WIDTH, 8, width of each event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- q_async  input  1  latch output; asynchronous to clk.
- clear  input  1  synchronous clear of both counters and overflow.
- level  output  1  debounced, synchronized copy of q_async.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- rise_count  output  CNT_WIDTH  number of accepted rises, saturating.
- fall_count  output  CNT_WIDTH  number of accepted falls, saturating.
- overflow  output  1  sticky; set when either counter saturates and another event of that kind occurs.

Behaviour:
- Reset (rst=1, asynchronous assert, released on any edge):
  - Sync chain is all 0; state is LOW; stability counter is 0.
  - level, rise, fall, overflow are 0; rise_count and fall_count are 0.
  - Reset mid-debounce discards the pending change.
- Synchronizer: the `s` signal is the output of the last flop. A change on q_async set up before edge 0 is visible on `s` after edge SYNC_STAGES-1.
- FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW. Stability counter `stab` is ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - LOW: if s=1 and DEBOUNCE_CYCLES=1, go to HIGH and assert the rise event. If s=1 otherwise, go to CHK_HIGH with stab=1. If s=0, stay.
  - CHK_HIGH: if s=0, go to LOW with stab=0 (glitch rejected, no pulse). If s=1 and stab=DEBOUNCE_CYCLES-1, go to HIGH and assert the rise event. Otherwise stab++.
  - HIGH and CHK_LOW: mirror images of LOW and CHK_HIGH, with polarity inverted and fall instead of rise.
- Outputs are registered:
  - level=1 in HIGH and CHK_LOW; level=0 in LOW and CHK_HIGH.
  - rise/fall are high for exactly the one cycle following the transition edge, coincident with the first cycle of the new level.
- End-to-end latency: q_async stable from edge 0 produces a level change and pulse after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is edge 5.
- Pulses shorter than DEBOUNCE_CYCLES synchronized samples produce no pulse and no count.
- Rise and fall can never be asserted in the same cycle.
- Counters:
  - A counter increments in the cycle its pulse is registered.
  - At all-ones it holds its value, and any further event of that kind sets overflow.
  - overflow stays set until clear or rst.
- clear:
  - Zeroes both counters and overflow at the next edge.
  - Takes priority over a coincident increment; that event is not counted, but its pulse is still emitted.
  - Does not affect the FSM, level, or the sync chain.

Decomposition:
- Package latch_pkg:
  - typedef enum logic [1:0] sampler_state_t {LOW, CHK_HIGH, HIGH, CHK_LOW}.
  - Helper function stab_width(DEBOUNCE_CYCLES).
- Sub-module sync_chain (parameter STAGES; ports clk, rst, d, q): a reusable shift-register synchronizer with async reset to 0.
- latch_sampler instantiates sync_chain and holds the FSM and counters.

Test Plan:
- Reset: assert rst mid-cycle with q_async=1 -> level, rise, fall, counts and overflow read 0 immediately, before the next edge.
- Clean rise, defaults: q_async 0->1 before edge 0, held -> level=1 and rise=1 for one cycle after edge 5; rise_count=1; fall stays 0.
- Glitch rejection: q_async high for 2 clock periods, then low -> level stays 0, no pulse, rise_count unchanged.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=2: toggle q_async every 3 cycles, 4 times -> level follows with 2-edge latency; rise_count=2, fall_count=2.
- Saturation, CNT_WIDTH=2: 5 clean rise/fall pairs -> rise_count=3, fall_count=3, overflow=1. Then pulse clear -> counts 0, overflow 0, level unchanged.
- Clear coincident with an accepted rise -> rise pulse seen, rise_count=0 on the following cycle.
